alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_settle_counter.sv | 28 ++
 rtl/alu_driver.sv | 92 +++++++++
 tb/tb_alu_driver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver: default width, ALU command encodings,
// driver FSM states and the response flag packing order.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W         = 8;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic logic [2:0] pack_flags(input logic carryout, input logic zero,
                                              input logic overflow);
        return {carryout, zero, overflow};
    endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// Down-counter timing how long the external ALU is given to settle.
// Loads on request accept, counts down while enabled, flags zero.
module alu_settle_counter
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_driver.sv
// Presents one request at a time to an external combinational ALU, waits
// SETTLE cycles, then captures result and flags into a held response.
module alu_driver
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int SETTLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_cmd,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [2:0]       rsp_cmd
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    state_e state;
    logic   accept;
    logic   drain;
    logic   cnt_zero;
    logic   cnt_dec;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_HOLD);
    assign accept    = req_valid && req_ready;
    assign drain     = rsp_valid && rsp_ready;
    assign cnt_dec   = (state == ST_SETTLE) && !cnt_zero;

    alu_settle_counter u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Operands stay on the ALU inputs until the next accept, so the ALU output
    // remains meaningful through HOLD and IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cmd    <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_cmd    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                        alu_cmd <= req_cmd;
                        state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= pack_flags(alu_carryout, alu_zero, alu_overflow);
                        rsp_cmd    <= alu_cmd;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (drain) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioral 32-bit ALU attached to its
// ALU-side ports; expected responses are hand-computed constants.
module tb_alu_driver;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a, req_b;
    logic [2:0]   req_cmd;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_cmd;
    logic [W-1:0] alu_result;
    logic         alu_carryout, alu_zero, alu_overflow;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_flags;
    logic [2:0]   rsp_cmd;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    alu_driver #(.WIDTH(W), .SETTLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cmd      (req_cmd),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_cmd      (alu_cmd),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_cmd      (rsp_cmd)
    );

    // Behavioral ALU: carry/overflow meaningful only for ADD and SUB.
    logic [W:0] sum;
    always_comb begin
        sum          = '0;
        alu_result   = '0;
        alu_carryout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_cmd)
            CMD_ADD: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum[W-1:0];
                alu_carryout = sum[W];
                alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
            CMD_SUB: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
                alu_result   = sum[W-1:0];
                alu_carryout = sum[W];
                alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
            CMD_XOR:  alu_result = alu_a ^ alu_b;
            CMD_SLT:  alu_result = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            CMD_AND:  alu_result = alu_a & alu_b;
            CMD_NAND: alu_result = ~(alu_a & alu_b);
            CMD_NOR:  alu_result = ~(alu_a | alu_b);
            default:  alu_result = alu_a | alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   cmd;
        logic [W-1:0] res;
        logic [2:0]   flags;
        int           stall;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        check("req_ready_idle", req_ready, 1);
        req_a     = v.a;
        req_b     = v.b;
        req_cmd   = v.cmd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("alu_a", alu_a, v.a);
        check("alu_b", alu_b, v.b);
        check("alu_cmd", alu_cmd, v.cmd);
        wait_rsp(lat);
        check("latency", lat, 16);
        check("rsp_result", rsp_result, v.res);
        check("rsp_flags", rsp_flags, v.flags);
        check("rsp_cmd", rsp_cmd, v.cmd);
        check("req_ready_hold", req_ready, 0);
        for (int i = 0; i < v.stall; i++) begin
            tick();
            check("stall_valid", rsp_valid, 1);
            check("stall_result", rsp_result, v.res);
            check("stall_flags", rsp_flags, v.flags);
            check("stall_cmd", rsp_cmd, v.cmd);
            check("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("drain_valid", rsp_valid, 0);
        check("drain_req_ready", req_ready, 1);
        check("idle_alu_a_held", alu_a, v.a);
    endtask

    initial begin
        int   lat;
        int   acc[2];
        int   n;
        logic seen;

        vecs[0]  = '{32'd0,        32'd1,        CMD_SLT,  32'd1,        3'b000, 0};
        vecs[1]  = '{32'd0,        32'hFFFFFFFF, CMD_NAND, 32'hFFFFFFFF, 3'b000, 0};
        vecs[2]  = '{32'd0,        32'd0,        CMD_ADD,  32'd0,        3'b010, 0};
        vecs[3]  = '{32'd223423,   32'd3232211,  CMD_ADD,  32'd3455634,  3'b000, 5};
        vecs[4]  = '{32'h7FFFFFFF, 32'd1,        CMD_ADD,  32'h80000000, 3'b001, 0};
        vecs[5]  = '{32'd5,        32'd3,        CMD_SUB,  32'd2,        3'b100, 0};
        vecs[6]  = '{32'hA5A5A5A5, 32'hFFFF0000, CMD_XOR,  32'h5A5AA5A5, 3'b000, 0};
        vecs[7]  = '{32'hF0F0F0F0, 32'h0FF00FF0, CMD_AND,  32'h00F000F0, 3'b000, 0};
        vecs[8]  = '{32'd0,        32'd0,        CMD_NOR,  32'hFFFFFFFF, 3'b000, 0};
        vecs[9]  = '{32'h12340000, 32'h00005678, CMD_OR,   32'h12345678, 3'b000, 0};
        vecs[10] = '{32'hFFFFFFFF, 32'd1,        CMD_ADD,  32'd0,        3'b110, 0};

        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_cmd   = '0;
        tick();
        tick();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_rsp_result", rsp_result, 0);
        reset = 1'b0;
        tick();
        check("rst_req_ready", req_ready, 1);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i]);
        end

        // Second request presented during SETTLE waits until after the drain.
        req_a = 32'h7FFFFFFF; req_b = 32'd1; req_cmd = CMD_ADD; req_valid = 1'b1;
        tick();
        req_a = 32'h11111111; req_b = 32'h22222222; req_cmd = CMD_ADD;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            check("busy_req_ready", req_ready, 0);
            check("busy_alu_a", alu_a, 32'h7FFFFFFF);
            tick();
            lat++;
        end
        check("busy_latency", lat, 16);
        check("ovf_result", rsp_result, 32'h80000000);
        check("ovf_flags", rsp_flags, 3'b001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_drain_alu_a", alu_a, 32'h7FFFFFFF);
        check("post_drain_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("second_alu_a", alu_a, 32'h11111111);
        wait_rsp(lat);
        check("second_latency", lat, 16);
        check("second_result", rsp_result, 32'h33333333);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Back-to-back throughput with both handshakes held high.
        req_a = 32'd7; req_b = 32'd9; req_cmd = CMD_OR;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        acc[0] = 0;
        acc[1] = 0;
        for (int c = 0; c < 60; c++) begin
            if (req_valid && req_ready && n < 2) begin
                acc[n] = c;
                n++;
            end
            tick();
            if (n == 2) req_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        check("tput_accepts", n, 2);
        check("tput_period", acc[1] - acc[0], 18);
        check("tput_idle", req_ready, 1);

        // Reset mid-SETTLE aborts the operation.
        req_a = 32'hDEADBEEF; req_b = 32'h1; req_cmd = CMD_XOR; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_alu_b", alu_b, 0);
        check("abort_alu_cmd", alu_cmd, 0);
        check("abort_rsp_result", rsp_result, 0);
        check("abort_rsp_flags", rsp_flags, 0);
        check("abort_rsp_cmd", rsp_cmd, 0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_req_ready", req_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("abort_no_rsp", seen, 0);
        run_op(vecs[6]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
